moore_seq_tx: RTL

//  Serial pattern transmitter; the source side of the Moore 1010 sequence-detector link.
//  On a start request it emits a fixed PAT_W-bit pattern MSB-first on a 1-bit serial line.
//  The pattern is repeated rep_i times, with an optional idle gap between repetitions.

---
 rtl/moore_seq_pkg.sv | 15 +
 rtl/seq_piso.sv | 45 ++++
 rtl/moore_seq_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/moore_seq_pkg.sv
// Shared definitions for the Moore 1010 serial pattern transmitter.
//   tx_state_t  : transmitter FSM states
//   DEF_PATTERN : default pattern shifted out MSB-first
package moore_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  localparam logic [3:0] DEF_PATTERN = 4'b1010;

endpackage : moore_seq_pkg

// File: rtl/seq_piso.sv
// Parallel-load / shift-left register used as the pattern shifter.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset, clears the register
//   load_i      : load data_i (takes priority over shift_i)
//   shift_i     : shift left by one, filling with 0
//   data_i      : parallel load value
//   msb_next_o  : MSB the register will hold after the coming edge, so the
//                 owner can register the serial bit alongside its other outputs
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_next_o
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    // NOTE: default first so every path assigns sh_d; otherwise a latch is inferred.
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      sh_d = {sh_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so all flops update together at the edge.
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_next_o = sh_d[W-1];

endmodule : seq_piso

// File: rtl/moore_seq_tx.sv
// Serial pattern transmitter: on start, emits PATTERN MSB-first rep_i times,
// with gap_i idle cycles between repetitions. All outputs are registered.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, aborts any transfer
//   start_i  : start request, sampled only in IDLE
//   rep_i    : repetition count, captured with start_i (0 = no bits, just done)
//   gap_i    : idle cycles between repetitions, captured with start_i
//   x_o      : serial data, 0 whenever valid_o is 0
//   valid_o  : x_o carries a pattern bit
//   frame_o  : last bit of each pattern
//   busy_o   : transfer in progress (SHIFT, GAP, DONE)
//   done_o   : one-cycle completion pulse
module moore_seq_tx
  import moore_seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               REP_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [REP_W-1:0] rep_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             x_o,
  output logic             valid_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int               CNT_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;     // index of the bit on x_o
  logic [REP_W-1:0] reps_q, reps_d;           // patterns left, including current
  logic [GAP_W-1:0] gap_len_q, gap_len_d;     // captured gap length
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;     // idle cycles left in GAP
  logic             x_q, valid_q, frame_q, busy_q, done_q;
  logic             x_d, valid_d, frame_d, busy_d, done_d;
  logic             piso_load, piso_shift, piso_msb_next;

  seq_piso #(.W(PAT_W)) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (piso_load),
    .shift_i    (piso_shift),
    .data_i     (PATTERN),
    .msb_next_o (piso_msb_next)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    reps_d     = reps_q;
    gap_len_d  = gap_len_q;
    gap_cnt_d  = gap_cnt_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (rep_i != '0) begin
            reps_d    = rep_i;
            gap_len_d = gap_i;
            bit_cnt_d = '0;
            piso_load = 1'b1;
            state_d   = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end

      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          reps_d    = reps_q - REP_W'(1);
          if (reps_q == REP_W'(1)) begin
            state_d = DONE;
          end else if (gap_len_q == '0) begin
            // Back-to-back: next pattern's first bit follows immediately.
            piso_load = 1'b1;
          end else begin
            gap_cnt_d = gap_len_q;
            state_d   = GAP;
          end
        end else begin
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          piso_shift = 1'b1;
        end
      end

      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        // Reload on the last idle cycle so the first bit appears right after.
        if (gap_cnt_q <= GAP_W'(1)) begin
          piso_load = 1'b1;
          state_d   = SHIFT;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Outputs are derived from next state so they are registered yet Moore.
    valid_d = (state_d == SHIFT);
    x_d     = valid_d & piso_msb_next;
    frame_d = valid_d && (bit_cnt_d == LAST_BIT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      reps_q    <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      reps_q    <= reps_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_o     = x_q;
  assign valid_o = valid_q;
  assign frame_o = frame_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule : moore_seq_tx
